// File: rtl/fifo_flags.sv
// Single-clock FIFO with registered status flags, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and normal or showahead read data.
module fifo_flags #(
   parameter int    AWIDTH       = 8,
   parameter int    DWIDTH       = 8,
   parameter string SHOWAHEAD    = "OFF",
   parameter int    ALMOST_FULL  = 2**AWIDTH - 2,
   parameter int    ALMOST_EMPTY = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              wrreq_i,
   input  logic              rdreq_i,
   input  logic              clr_err_i,
   output logic [DWIDTH-1:0] q_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              almost_empty_o,
   output logic              almost_full_o,
   output logic [AWIDTH:0]   usedw_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam int DEPTH = 2**AWIDTH;
   localparam bit SHOW  = (SHOWAHEAD == "ON");

   localparam logic [AWIDTH:0]   FULL_LVL = {1'b1, {AWIDTH{1'b0}}};
   localparam logic [AWIDTH:0]   AF_LVL   = ALMOST_FULL[AWIDTH:0];
   localparam logic [AWIDTH:0]   AE_LVL   = ALMOST_EMPTY[AWIDTH:0];
   localparam logic [AWIDTH:0]   CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};
   localparam logic [AWIDTH-1:0] PTR_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};

   if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_almost_full
      $fatal(1, "fifo_flags: ALMOST_FULL must lie in 1..DEPTH");
   end
   if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > DEPTH - 1) begin : g_bad_almost_empty
      $fatal(1, "fifo_flags: ALMOST_EMPTY must lie in 0..DEPTH-1");
   end
   if (SHOWAHEAD != "ON" && SHOWAHEAD != "OFF") begin : g_bad_showahead
      $fatal(1, "fifo_flags: SHOWAHEAD must be \"ON\" or \"OFF\"");
   end

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AWIDTH-1:0] wr_ptr;
   logic [AWIDTH-1:0] rd_ptr;
   logic [AWIDTH-1:0] rd_ptr_inc;
   logic [AWIDTH:0]   count_nxt;
   logic [DWIDTH-1:0] q_nxt;
   logic              rd_acc;
   logic              wr_acc;

   // A full FIFO may still take a write when the same edge pops a word.
   always_comb begin
      rd_acc     = rdreq_i & ~empty_o;
      wr_acc     = wrreq_i & (~full_o | rd_acc);
      rd_ptr_inc = rd_ptr + PTR_ONE;
      count_nxt  = usedw_o;
      if (wr_acc && !rd_acc) begin
         count_nxt = usedw_o + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
         count_nxt = usedw_o - CNT_ONE;
      end
   end

   // Showahead keeps q_o on the head word: after a pop it is the next stored word,
   // or the word being written this edge when the FIFO held only one word.
   always_comb begin
      q_nxt = q_o;
      if (SHOW) begin
         if (rd_acc) begin
            if (usedw_o == CNT_ONE) begin
               if (wr_acc) begin
                  q_nxt = data_i;
               end
            end else begin
               q_nxt = mem[rd_ptr_inc];
            end
         end else if (empty_o && wr_acc) begin
            q_nxt = data_i;
         end
      end else if (rd_acc) begin
         q_nxt = mem[rd_ptr];
      end
   end

   // NOTE: the storage array has no reset; only pointers and the count define validity.
   always_ff @(posedge clk_i) begin
      if (wr_acc) begin
         mem[wr_ptr] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         usedw_o        <= '0;
         empty_o        <= 1'b1;
         full_o         <= 1'b0;
         almost_empty_o <= 1'b1;
         almost_full_o  <= 1'b0;
         q_o            <= '0;
         overflow_o     <= 1'b0;
         underflow_o    <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr_inc;
         end
         usedw_o        <= count_nxt;
         empty_o        <= (count_nxt == '0);
         full_o         <= (count_nxt == FULL_LVL);
         almost_empty_o <= (count_nxt <= AE_LVL);
         almost_full_o  <= (count_nxt >= AF_LVL);
         q_o            <= q_nxt;
         // A fresh rejection outranks a coincident clear.
         overflow_o     <= (wrreq_i & ~wr_acc) | (overflow_o & ~clr_err_i);
         underflow_o    <= (rdreq_i & ~rd_acc) | (underflow_o & ~clr_err_i);
      end
   end

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: normal and showahead instances share stimulus and are compared
// every cycle against a queue-based model, with directed boundary sequences then random traffic.
module tb_fifo_flags;

   localparam int AW    = 3;
   localparam int DW    = 8;
   localparam int DEPTH = 2**AW;
   localparam int AF    = DEPTH - 2;
   localparam int AE    = 1;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] data;
   logic          wrreq;
   logic          rdreq;
   logic          clr_err;

   logic [DW-1:0] q_off, q_on;
   logic          empty_off, empty_on, full_off, full_on;
   logic          ae_off, ae_on, af_off, af_on;
   logic [AW:0]   usedw_off, usedw_on;
   logic          ovf_off, ovf_on, udf_off, udf_on;

   fifo_flags #(.AWIDTH(AW), .DWIDTH(DW), .SHOWAHEAD("OFF")) u_off (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
      .clr_err_i(clr_err), .q_o(q_off), .empty_o(empty_off), .full_o(full_off),
      .almost_empty_o(ae_off), .almost_full_o(af_off), .usedw_o(usedw_off),
      .overflow_o(ovf_off), .underflow_o(udf_off)
   );

   fifo_flags #(.AWIDTH(AW), .DWIDTH(DW), .SHOWAHEAD("ON")) u_on (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
      .clr_err_i(clr_err), .q_o(q_on), .empty_o(empty_on), .full_o(full_on),
      .almost_empty_o(ae_on), .almost_full_o(af_on), .usedw_o(usedw_on),
      .overflow_o(ovf_on), .underflow_o(udf_on)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_q_off;
   logic [DW-1:0] m_q_on;
   logic          m_ovf;
   logic          m_udf;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_q_off = '0;
      m_q_on  = '0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
   endtask

   task automatic model_step(input logic wr, input logic rd, input logic [DW-1:0] d,
                             input logic clr);
      bit ra, wa;
      ra    = rd && (mq.size() > 0);
      wa    = wr && ((mq.size() < DEPTH) || ra);
      m_ovf = (wr && !wa) || (m_ovf && !clr);
      m_udf = (rd && !ra) || (m_udf && !clr);
      if (ra) m_q_off = mq.pop_front();
      if (wa) mq.push_back(d);
      if (mq.size() > 0) m_q_on = mq[0];
   endtask

   task automatic check_all();
      int n;
      n = mq.size();
      check("usedw_off", 32'(usedw_off), n);
      check("usedw_on",  32'(usedw_on),  n);
      check("empty_off", 32'(empty_off), 32'(n == 0));
      check("empty_on",  32'(empty_on),  32'(n == 0));
      check("full_off",  32'(full_off),  32'(n == DEPTH));
      check("full_on",   32'(full_on),   32'(n == DEPTH));
      check("aempty",    32'(ae_off),    32'(n <= AE));
      check("afull",     32'(af_on),     32'(n >= AF));
      check("ovf",       32'(ovf_off),   32'(m_ovf));
      check("udf",       32'(udf_on),    32'(m_udf));
      check("q_off",     32'(q_off),     32'(m_q_off));
      check("q_on",      32'(q_on),      32'(m_q_on));
   endtask

   // Inputs change just after the falling edge; outputs are checked on the next falling edge.
   task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d,
                        input logic clr);
      wrreq   = wr;
      rdreq   = rd;
      data    = d;
      clr_err = clr;
      @(posedge clk);
      model_step(wr, rd, d, clr);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      rst_n   = 1'b0;
      wrreq   = 1'b0;
      rdreq   = 1'b0;
      clr_err = 1'b0;
      data    = '0;
      model_reset();
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      @(negedge clk);

      // Fill to full, then one rejected write.
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(1'b1, 1'b0, DW'(i), 1'b0);
         if (i == AF - 1) check("af_below", 32'(af_off), 0);
         if (i == AF)     check("af_at",    32'(af_off), 1);
      end
      check("full_at_8", 32'(full_off), 1);
      cycle(1'b1, 1'b0, 8'hFF, 1'b0);
      check("ovf_9th", 32'(ovf_off), 1);
      check("usedw_9th", 32'(usedw_off), DEPTH);

      // Simultaneous read/write while full.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b1, DW'(8'h10 + i), 1'b0);
         check("full_rw", 32'(full_off), 1);
         check("q_off_rw", 32'(q_off), 32'(i + 1));
      end

      // Drain, then one read of the empty FIFO, then clear.
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
      check("q_off_last", 32'(q_off), 32'h13);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      check("udf_empty", 32'(udf_off), 1);
      check("q_hold_udf", 32'(q_off), 32'h13);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check("udf_clr", 32'(udf_off), 0);

      // Showahead from empty.
      cycle(1'b1, 1'b0, 8'hAA, 1'b0);
      check("sa_aa", 32'(q_on), 32'hAA);
      check("sa_nempty", 32'(empty_on), 0);
      cycle(1'b1, 1'b0, 8'hBB, 1'b0);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      check("sa_bb", 32'(q_on), 32'hBB);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);

      // Clear error on the same edge as a new error: the new error wins.
      cycle(1'b0, 1'b1, 8'h00, 1'b1);
      check("clr_vs_new", 32'(udf_on), 1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);

      // Asynchronous reset mid-operation.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
      wrreq = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      check("udf_after_rst", 32'(udf_off), 1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);

      // Random traffic.
      for (int i = 0; i < 10000; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom),
               1'($urandom_range(0, 15) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
